// File: rtl/rdata_serializer.sv
// Buffers 16-bit HyperRAM read words in a small FIFO and streams each one to the
// UART transmitter as two bytes, paced by the transmitter's busy handshake.
module rdata_serializer #(
  parameter int DEPTH_LOG2 = 3,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GUARD      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           mdata,
  input  logic                  mdata_ready,
  output logic [7:0]            send_byte,
  output logic                  send_imp,
  input  logic                  serial_busy,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int                   DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]  CNT_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]  CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [1:0]           GUARD_MAX = 2'(GUARD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND1,
    S_ARM1,
    S_DRAIN1,
    S_SEND2,
    S_ARM2,
    S_DRAIN2
  } state_e;

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic [15:0]             hold_q, hold_d;
  logic [1:0]              guard_q, guard_d;
  logic                    send_imp_q, send_imp_d;
  logic [7:0]              send_byte_q, send_byte_d;
  logic                    empty_q, empty_d;
  logic                    full_q, full_d;
  logic                    overflow_q, overflow_d;

  logic [15:0]             mem_q [DEPTH];
  logic [15:0]             rd_word;
  logic                    push;
  logic                    pop;

  function automatic logic [7:0] first_byte(input logic [15:0] w);
    return MSB_FIRST ? w[15:8] : w[7:0];
  endfunction

  function automatic logic [7:0] second_byte(input logic [15:0] w);
    return MSB_FIRST ? w[7:0] : w[15:8];
  endfunction

  assign rd_word = mem_q[rd_ptr_q];

  // The outgoing byte and pulse are computed one state early so they leave a flop.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d     = state_q;
    hold_d      = hold_q;
    guard_d     = guard_q;
    send_imp_d  = 1'b0;
    send_byte_d = 8'h00;
    pop         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0 && !serial_busy) begin
          pop         = 1'b1;
          hold_d      = rd_word;
          send_imp_d  = 1'b1;
          send_byte_d = first_byte(rd_word);
          state_d     = S_SEND1;
        end
      end
      S_SEND1: begin
        guard_d = 2'd0;
        state_d = S_ARM1;
      end
      S_ARM1: begin
        guard_d = guard_q + 2'd1;
        if (serial_busy || guard_d == GUARD_MAX) state_d = S_DRAIN1;
      end
      S_DRAIN1: begin
        if (!serial_busy) begin
          send_imp_d  = 1'b1;
          send_byte_d = second_byte(hold_q);
          state_d     = S_SEND2;
        end
      end
      S_SEND2: begin
        guard_d = 2'd0;
        state_d = S_ARM2;
      end
      S_ARM2: begin
        guard_d = guard_q + 2'd1;
        if (serial_busy || guard_d == GUARD_MAX) state_d = S_DRAIN2;
      end
      S_DRAIN2: begin
        if (!serial_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A push into a full FIFO is only legal when the same cycle frees a slot.
  always_comb begin
    push     = mdata_ready && (count_q != CNT_FULL || pop);
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q || (mdata_ready && !push);
    empty_d    = (count_d == '0) && (state_d == S_IDLE);
    full_d     = (count_d == CNT_FULL);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      hold_q      <= 16'h0000;
      guard_q     <= 2'd0;
      send_imp_q  <= 1'b0;
      send_byte_q <= 8'h00;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      hold_q      <= hold_d;
      guard_q     <= guard_d;
      send_imp_q  <= send_imp_d;
      send_byte_q <= send_byte_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset; count and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= mdata;
  end

  assign send_imp  = send_imp_q;
  assign send_byte = send_byte_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign overflow  = overflow_q;
  assign level     = count_q;

endmodule

// File: tb/tb_rdata_serializer.sv
// Scoreboard bench for rdata_serializer: an MSB-first instance exercised through
// single, burst, overflow, full-with-pop, guard-timeout and reset cases, plus an LSB-first instance.
`timescale 1ns/1ps
module tb_rdata_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mdata;
  logic        mdata_ready_a, mdata_ready_b;

  logic [7:0]  send_byte_a, send_byte_b;
  logic        send_imp_a, send_imp_b;
  logic        serial_busy_a, serial_busy_b;
  logic        empty_a, empty_b, full_a, full_b, overflow_a, overflow_b;
  logic [3:0]  level_a, level_b;

  logic        hold_busy_a, never_busy_a;
  int          busy_cnt_a, busy_cnt_b;

  logic [7:0]  exp_a[$];
  logic [7:0]  exp_b[$];
  int          pulse_cnt_a, pulse_cnt_b;
  int          n_cmp, n_bad;

  always #5 clk = ~clk;

  rdata_serializer #(.DEPTH_LOG2(3), .MSB_FIRST(1'b1), .GUARD(3)) dut_a (
    .clk(clk), .rst(rst), .mdata(mdata), .mdata_ready(mdata_ready_a),
    .send_byte(send_byte_a), .send_imp(send_imp_a), .serial_busy(serial_busy_a),
    .empty(empty_a), .full(full_a), .overflow(overflow_a), .level(level_a)
  );

  rdata_serializer #(.DEPTH_LOG2(3), .MSB_FIRST(1'b0), .GUARD(3)) dut_b (
    .clk(clk), .rst(rst), .mdata(mdata), .mdata_ready(mdata_ready_b),
    .send_byte(send_byte_b), .send_imp(send_imp_b), .serial_busy(serial_busy_b),
    .empty(empty_b), .full(full_b), .overflow(overflow_b), .level(level_b)
  );

  // Transmitter models: busy rises the cycle after a send pulse and stays up for 4 cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) busy_cnt_a <= 0;
    else if (send_imp_a && !never_busy_a) busy_cnt_a <= 4;
    else if (busy_cnt_a != 0) busy_cnt_a <= busy_cnt_a - 1;
  end
  assign serial_busy_a = hold_busy_a || (busy_cnt_a != 0);

  always @(posedge clk or posedge rst) begin
    if (rst) busy_cnt_b <= 0;
    else if (send_imp_b) busy_cnt_b <= 4;
    else if (busy_cnt_b != 0) busy_cnt_b <= busy_cnt_b - 1;
  end
  assign serial_busy_b = (busy_cnt_b != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: pop one expected byte per send pulse.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (send_imp_a) begin
          pulse_cnt_a++;
          if (exp_a.size() == 0) check("a_unexpected_pulse", {24'h0, send_byte_a}, 32'hFFFF_FFFF);
          else begin
            e = exp_a.pop_front();
            check("a_byte", {24'h0, send_byte_a}, {24'h0, e});
          end
        end else begin
          check("a_idle_byte_zero", {24'h0, send_byte_a}, 32'h0);
        end
      end
    end
  end

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst && send_imp_b) begin
        pulse_cnt_b++;
        if (exp_b.size() == 0) check("b_unexpected_pulse", {24'h0, send_byte_b}, 32'hFFFF_FFFF);
        else begin
          e = exp_b.pop_front();
          check("b_byte", {24'h0, send_byte_b}, {24'h0, e});
        end
      end
    end
  end

  task automatic push_a(input logic [15:0] w, input bit accept);
    mdata         = w;
    mdata_ready_a = 1'b1;
    if (accept) begin
      exp_a.push_back(w[15:8]);
      exp_a.push_back(w[7:0]);
    end
    @(negedge clk);
    mdata_ready_a = 1'b0;
  endtask

  task automatic wait_drain_a(input string name, input int budget);
    int n = 0;
    while ((exp_a.size() != 0 || !empty_a || serial_busy_a) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'h0, n < budget}, 32'h1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #400us;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, peak, first, second, n;
    n_cmp = 0; n_bad = 0; pulse_cnt_a = 0; pulse_cnt_b = 0;
    rst = 1'b1; mdata = 16'h0; mdata_ready_a = 1'b0; mdata_ready_b = 1'b0;
    hold_busy_a = 1'b0; never_busy_a = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_send_imp",  {31'h0, send_imp_a}, 32'h0);
    check("rst_send_byte", {24'h0, send_byte_a}, 32'h0);
    check("rst_empty",     {31'h0, empty_a}, 32'h1);
    check("rst_full",      {31'h0, full_a}, 32'h0);
    check("rst_overflow",  {31'h0, overflow_a}, 32'h0);
    check("rst_level",     {28'h0, level_a}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single word: latency, one-cycle pulse, exactly two bytes
    base = pulse_cnt_a;
    push_a(16'hAA55, 1'b1);
    check("single_level_after_push", {28'h0, level_a}, 32'h1);
    check("single_no_pulse_yet", {31'h0, send_imp_a}, 32'h0);
    @(negedge clk);
    check("single_latency", {31'h0, send_imp_a}, 32'h1);
    @(negedge clk);
    check("single_pulse_width", {31'h0, send_imp_a}, 32'h0);
    wait_drain_a("single_drain", 200);
    repeat (5) @(negedge clk);
    check("single_pulse_count", pulse_cnt_a - base, 32'd2);
    check("single_empty", {31'h0, empty_a}, 32'h1);

    // Burst of 4 back-to-back strobes
    peak = 0;
    push_a(16'h1122, 1'b1); if (int'(level_a) > peak) peak = int'(level_a);
    push_a(16'h3344, 1'b1); if (int'(level_a) > peak) peak = int'(level_a);
    push_a(16'h5566, 1'b1); if (int'(level_a) > peak) peak = int'(level_a);
    push_a(16'h7788, 1'b1); if (int'(level_a) > peak) peak = int'(level_a);
    @(negedge clk);         if (int'(level_a) > peak) peak = int'(level_a);
    check("burst_level_peak", {31'h0, (peak == 3 || peak == 4)}, 32'h1);
    wait_drain_a("burst_drain", 400);

    // Overflow while the transmitter is held busy
    hold_busy_a = 1'b1;
    for (int i = 1; i <= 8; i++) push_a(16'(i), 1'b1);
    check("ovf_full_after_8", {31'h0, full_a}, 32'h1);
    check("ovf_level_8", {28'h0, level_a}, 32'h8);
    check("ovf_not_yet", {31'h0, overflow_a}, 32'h0);
    push_a(16'h0009, 1'b0);
    check("ovf_set", {31'h0, overflow_a}, 32'h1);
    check("ovf_level_still_8", {28'h0, level_a}, 32'h8);
    hold_busy_a = 1'b0;
    wait_drain_a("ovf_drain", 600);
    check("ovf_sticky", {31'h0, overflow_a}, 32'h1);
    check("ovf_empty", {31'h0, empty_a}, 32'h1);
    do_reset();
    check("ovf_cleared_by_rst", {31'h0, overflow_a}, 32'h0);

    // Full FIFO with push in the pop cycle
    hold_busy_a = 1'b1;
    for (int i = 0; i < 8; i++) push_a({8'hC0, 8'(i)}, 1'b1);
    check("fullpop_full", {31'h0, full_a}, 32'h1);
    mdata         = 16'hBEEF;
    mdata_ready_a = 1'b1;
    hold_busy_a   = 1'b0;
    exp_a.push_back(8'hBE);
    exp_a.push_back(8'hEF);
    @(negedge clk);
    mdata_ready_a = 1'b0;
    check("fullpop_level_8", {28'h0, level_a}, 32'h8);
    check("fullpop_no_overflow", {31'h0, overflow_a}, 32'h0);
    check("fullpop_still_full", {31'h0, full_a}, 32'h1);
    wait_drain_a("fullpop_drain", 700);
    check("fullpop_overflow_final", {31'h0, overflow_a}, 32'h0);

    // Guard timeout: transmitter never raises busy
    never_busy_a = 1'b1;
    first = -1; second = -1;
    push_a(16'h1234, 1'b1);
    if (send_imp_a) first = 0;
    for (int c = 1; c < 40; c++) begin
      @(negedge clk);
      if (send_imp_a) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    check("guard_both_bytes", {31'h0, (first >= 0 && second >= 0)}, 32'h1);
    check("guard_gap_bounded", {31'h0, (second > first && second - first <= 8)}, 32'h1);
    check("guard_empty", {31'h0, empty_a}, 32'h1);
    never_busy_a = 1'b0;
    wait_drain_a("guard_drain", 50);

    // Reset while draining the first byte with three words queued
    push_a(16'h0102, 1'b0);
    exp_a.push_back(8'h01);
    push_a(16'h0304, 1'b0);
    push_a(16'h0506, 1'b0);
    @(negedge clk);
    check("rstmid_first_byte_sent", exp_a.size(), 32'h0);
    check("rstmid_busy_high", {31'h0, serial_busy_a}, 32'h1);
    rst = 1'b1;
    #1;
    check("rstmid_send_imp", {31'h0, send_imp_a}, 32'h0);
    check("rstmid_level", {28'h0, level_a}, 32'h0);
    check("rstmid_empty", {31'h0, empty_a}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    base = pulse_cnt_a;
    repeat (30) @(negedge clk);
    check("rstmid_no_more_pulses", pulse_cnt_a - base, 32'h0);

    // LSB-first instance
    base = pulse_cnt_b;
    exp_b.push_back(8'h55);
    exp_b.push_back(8'hAA);
    mdata         = 16'hAA55;
    mdata_ready_b = 1'b1;
    @(negedge clk);
    mdata_ready_b = 1'b0;
    n = 0;
    while ((exp_b.size() != 0 || !empty_b || serial_busy_b) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("lsb_drain", {31'h0, n < 200}, 32'h1);
    repeat (5) @(negedge clk);
    check("lsb_pulse_count", pulse_cnt_b - base, 32'd2);

    check("final_queue_a_empty", exp_a.size(), 32'h0);
    check("final_queue_b_empty", exp_b.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
